// File: rtl/cm_frame_seq_if.sv
// Bundle between the frame sequencer and the 3x3 filter datapath / BRAMs.
// The sequencer takes the master side; the datapath and memories take the slave side.
interface cm_frame_seq_if #(
   parameter int ADDR_W = 12
);
   logic              start;
   logic              ena;
   logic [ADDR_W-1:0] addra;
   logic              tap_valid;
   logic              tap_first;
   logic [2:0]        sel;
   logic              enb;
   logic              wea1;
   logic [ADDR_W-1:0] addrb;
   logic              busy;
   logic              complete;

   modport master (
      input  start,
      output ena, addra, tap_valid, tap_first, sel,
      output enb, wea1, addrb, busy, complete
   );

   modport slave (
      output start,
      input  ena, addra, tap_valid, tap_first, sel,
      input  enb, wea1, addrb, busy, complete
   );
endinterface

// File: rtl/cm_frame_seq.sv
// Frame sequencer for the 3x3 neighbourhood filter.
// Walks every interior pixel in raster order. For each pixel it reads the
// 8 neighbours, waits for the BRAM read latency, then writes one result.
// Every output is a flop, so start has no combinational path to any output.
module cm_frame_seq #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   cm_frame_seq_if.master bus
);

   typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] W       = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] NEG_W   = ADDR_W'(0) - W;
   localparam logic [ADDR_W-1:0] NEG_ONE = ADDR_W'(0) - ONE;
   localparam logic [ADDR_W-1:0] XMAX    = ADDR_W'(IMG_W - 2);
   localparam logic [ADDR_W-1:0] YMAX    = ADDR_W'(IMG_H - 2);
   localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);

   // Neighbour offsets from the centre pixel, in tap order (row above, same row, row below).
   localparam logic [ADDR_W-1:0] OFF [8] = '{
      NEG_W - ONE, NEG_W, NEG_W + ONE,
      NEG_ONE,            ONE,
      W - ONE,     W,     W + ONE
   };

   state_t            state, stateNext;
   logic [2:0]        tap, tapNext;
   logic [2:0]        drainCnt, drainCntNext;
   logic [ADDR_W-1:0] x, xNext;
   logic [ADDR_W-1:0] y, yNext;
   logic [ADDR_W-1:0] rowBase, rowBaseNext;

   logic              enaNext, enbNext, busyNext, completeNext;
   logic [ADDR_W-1:0] addraNext, addrbNext;

   logic              enaReg, enbReg, wea1Reg, busyReg, completeReg;
   logic [ADDR_W-1:0] addraReg, addrbReg;
   logic              tapValidReg, tapFirstReg;
   logic [2:0]        selReg;

   logic [RD_LAT-1:0] vPipe;
   logic [2:0]        tPipe [RD_LAT];

   // Next-state logic: walks taps, drain cycles and the pixel raster; the row
   // base is advanced by IMG_W per row so no multiplier is needed.
   always_comb begin
      stateNext    = state;
      tapNext      = tap;
      drainCntNext = drainCnt;
      xNext        = x;
      yNext        = y;
      rowBaseNext  = rowBase;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               stateNext   = READ;
               tapNext     = '0;
               xNext       = ONE;
               yNext       = ONE;
               rowBaseNext = W;
            end
         end
         READ: begin
            if (tap == 3'd7) begin
               stateNext    = DRAIN;
               drainCntNext = '0;
            end else begin
               tapNext = tap + 3'd1;
            end
         end
         DRAIN: begin
            if (drainCnt == DRAIN_LAST) begin
               stateNext = WRITE;
            end else begin
               drainCntNext = drainCnt + 3'd1;
            end
         end
         WRITE: begin
            tapNext = '0;
            if (x < XMAX) begin
               xNext     = x + ONE;
               stateNext = READ;
            end else begin
               xNext = ONE;
               if (y < YMAX) begin
                  yNext       = y + ONE;
                  rowBaseNext = rowBase + W;
                  stateNext   = READ;
               end else begin
                  stateNext = DONE;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Output values for the coming cycle, derived from the next state so they can be registered.
   always_comb begin
      enaNext      = (stateNext == READ);
      addraNext    = rowBaseNext + xNext + OFF[tapNext];
      enbNext      = (stateNext == WRITE);
      addrbNext    = enbNext ? (rowBaseNext + xNext) : addrbReg;
      busyNext     = (stateNext == READ) || (stateNext == DRAIN) || (stateNext == WRITE);
      completeNext = (stateNext == DONE);
   end

   // State, raster position and registered control outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tap         <= '0;
         drainCnt    <= '0;
         x           <= ONE;
         y           <= ONE;
         rowBase     <= W;
         enaReg      <= 1'b0;
         addraReg    <= '0;
         enbReg      <= 1'b0;
         wea1Reg     <= 1'b0;
         addrbReg    <= '0;
         busyReg     <= 1'b0;
         completeReg <= 1'b0;
      end else begin
         state       <= stateNext;
         tap         <= tapNext;
         drainCnt    <= drainCntNext;
         x           <= xNext;
         y           <= yNext;
         rowBase     <= rowBaseNext;
         enaReg      <= enaNext;
         addraReg    <= addraNext;
         enbReg      <= enbNext;
         wea1Reg     <= enbNext;
         addrbReg    <= addrbNext;
         busyReg     <= busyNext;
         completeReg <= completeNext;
      end
   end

   // Delays "read issued" and its tap index by RD_LAT so tap_valid/sel line up with BRAM data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vPipe       <= '0;
         for (int i = 0; i < RD_LAT; i++) tPipe[i] <= '0;
         tapValidReg <= 1'b0;
         tapFirstReg <= 1'b0;
         selReg      <= '0;
      end else begin
         vPipe[0] <= enaNext;
         tPipe[0] <= tapNext;
         for (int i = 1; i < RD_LAT; i++) begin
            vPipe[i] <= vPipe[i-1];
            tPipe[i] <= tPipe[i-1];
         end
         tapValidReg <= vPipe[RD_LAT-1];
         tapFirstReg <= vPipe[RD_LAT-1] && (tPipe[RD_LAT-1] == 3'd0);
         if (vPipe[RD_LAT-1]) selReg <= tPipe[RD_LAT-1];
      end
   end

   assign bus.ena       = enaReg;
   assign bus.addra     = addraReg;
   assign bus.tap_valid = tapValidReg;
   assign bus.tap_first = tapFirstReg;
   assign bus.sel       = selReg;
   assign bus.enb       = enbReg;
   assign bus.wea1      = wea1Reg;
   assign bus.addrb     = addrbReg;
   assign bus.busy      = busyReg;
   assign bus.complete  = completeReg;

endmodule

// File: tb/tb_cm_frame_seq.sv
// Testbench for cm_frame_seq: three instances (4x4 RD_LAT=2, 4x4 RD_LAT=1,
// 6x5 RD_LAT=3) checked cycle by cycle against a per-cycle arithmetic model
// of the frame schedule.
module tb_cm_frame_seq;

   typedef struct packed {
      logic        ena;
      logic [11:0] addra;
      logic        tap_valid;
      logic        tap_first;
      logic [2:0]  sel;
      logic        enb;
      logic        wea1;
      logic [11:0] addrb;
      logic        busy;
      logic        complete;
   } obs_t;

   logic       clk;
   logic       rst_n;
   logic [2:0] startv;
   obs_t       obs [3];
   obs_t       obsQ [$];

   int checks;
   int failures;

   int cfgW [3] = '{4, 4, 6};
   int cfgH [3] = '{4, 4, 5};
   int cfgL [3] = '{2, 1, 3};
   int dxTab [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
   int dyTab [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

   logic [2:0]  prevSel [3];
   logic [11:0] prevAddrb [3];

   cm_frame_seq_if #(.ADDR_W(12)) ifA ();
   cm_frame_seq_if #(.ADDR_W(12)) ifB ();
   cm_frame_seq_if #(.ADDR_W(12)) ifC ();

   assign ifA.start = startv[0];
   assign ifB.start = startv[1];
   assign ifC.start = startv[2];

   cm_frame_seq #(.IMG_W(4), .IMG_H(4), .ADDR_W(12), .RD_LAT(2)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
   cm_frame_seq #(.IMG_W(4), .IMG_H(4), .ADDR_W(12), .RD_LAT(1)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
   cm_frame_seq #(.IMG_W(6), .IMG_H(5), .ADDR_W(12), .RD_LAT(3)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

   assign obs[0] = {ifA.ena, ifA.addra, ifA.tap_valid, ifA.tap_first, ifA.sel,
                    ifA.enb, ifA.wea1, ifA.addrb, ifA.busy, ifA.complete};
   assign obs[1] = {ifB.ena, ifB.addra, ifB.tap_valid, ifB.tap_first, ifB.sel,
                    ifB.enb, ifB.wea1, ifB.addrb, ifB.busy, ifB.complete};
   assign obs[2] = {ifC.ena, ifC.addra, ifC.tap_valid, ifC.tap_first, ifC.sel,
                    ifC.enb, ifC.wea1, ifC.addrb, ifC.busy, ifC.complete};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected outputs k cycles after the first READ of a frame, from the raster schedule.
   function automatic obs_t modelAt(input int idx, input int k, input logic [2:0] ps, input logic [11:0] pa);
      obs_t o;
      int w, h, l, per, n, p, ph, kk, px, py, qx, qy;
      w   = cfgW[idx];
      h   = cfgH[idx];
      l   = cfgL[idx];
      per = 9 + l;
      n   = (w - 2) * (h - 2);
      o   = '0;
      o.sel   = ps;
      o.addrb = pa;
      kk = k - l;
      if (kk >= 0) begin
         if (kk % per < 8) begin
            o.tap_valid = 1'b1;
            o.sel       = 3'(kk % per);
            o.tap_first = (kk % per == 0);
         end else begin
            o.sel = 3'd7;
         end
      end
      p  = k / per;
      ph = k % per;
      if (p > 0) begin
         qx = 1 + (p - 1) % (w - 2);
         qy = 1 + (p - 1) / (w - 2);
         o.addrb = 12'(qy * w + qx);
      end
      if (k < n * per) begin
         o.busy = 1'b1;
         px = 1 + p % (w - 2);
         py = 1 + p / (w - 2);
         if (ph < 8) begin
            o.ena   = 1'b1;
            o.addra = 12'((py + dyTab[ph]) * w + px + dxTab[ph]);
         end
         if (ph == 8 + l) begin
            o.enb   = 1'b1;
            o.wea1  = 1'b1;
            o.addrb = 12'(py * w + px);
         end
      end else begin
         o.complete = 1'b1;
      end
      return o;
   endfunction

   function automatic obs_t masked(input obs_t o);
      obs_t r;
      r = o;
      if (!r.ena) r.addra = '0;
      return r;
   endfunction

   function automatic int frameCycles(input int idx);
      return (cfgW[idx] - 2) * (cfgH[idx] - 2) * (9 + cfgL[idx]);
   endfunction

   // Pulses start on one instance and records its outputs from the first READ through DONE.
   task automatic captureFrame(input int idx, input int midAt);
      int total;
      total = frameCycles(idx) + 1;
      obsQ.delete();
      @(negedge clk);
      startv[idx] = 1'b1;
      for (int k = 0; k < total; k++) begin
         @(negedge clk);
         obsQ.push_back(obs[idx]);
         startv[idx] = (k == midAt);
      end
      startv[idx] = 1'b0;
   endtask

   task automatic applyStimulus_reset();
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
   endtask

   task automatic test_reset();
      applyStimulus_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i] !== '0) begin
            failures++;
            $display("[TB] FAIL reset_assert inst%0d got=%h want=0", i, obs[i]);
         end
         prevSel[i]   = '0;
         prevAddrb[i] = '0;
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== '0) begin
               failures++;
               $display("[TB] FAIL reset_idle inst%0d cyc=%0d got=%h want=0", i, c, obs[i]);
            end
         end
      end
   endtask

   task automatic test_frame_4x4();
      int expRd [8] = '{0, 1, 2, 4, 6, 8, 9, 10};
      int expWr [4] = '{5, 6, 9, 10};
      int nWr, nFirst, doneAt;
      obs_t e;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      captureFrame(0, -1);
      for (int k = 0; k < obsQ.size(); k++) begin
         e = modelAt(0, k, prevSel[0], prevAddrb[0]);
         checks++;
         if (masked(obsQ[k]) !== e) begin
            failures++;
            $display("[TB] FAIL frame4x4 k=%0d got=%h want=%h", k, masked(obsQ[k]), e);
         end
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (obsQ[k].ena !== 1'b1 || int'(obsQ[k].addra) != expRd[k]) begin
            failures++;
            $display("[TB] FAIL read_addr t=%0d got=%0d want=%0d", k, obsQ[k].addra, expRd[k]);
         end
      end
      nWr = 0; nFirst = 0; doneAt = -1;
      for (int k = 0; k < obsQ.size(); k++) begin
         if (obsQ[k].wea1 === 1'b1) begin
            checks++;
            if (nWr >= 4 || int'(obsQ[k].addrb) != expWr[nWr % 4] || k != 10 + 11 * nWr) begin
               failures++;
               $display("[TB] FAIL write_seq n=%0d k=%0d got=%0d want=%0d at k=%0d", nWr, k, obsQ[k].addrb, expWr[nWr % 4], 10 + 11 * nWr);
            end
            nWr++;
         end
         if (obsQ[k].tap_first === 1'b1) nFirst++;
         if (doneAt < 0 && obsQ[k].complete === 1'b1) doneAt = k;
         checks++;
         if (obsQ[k].tap_valid !== (k >= 2 && (k - 2) % 11 < 8)) begin
            failures++;
            $display("[TB] FAIL tap_align k=%0d got=%b", k, obsQ[k].tap_valid);
         end
      end
      checks++;
      if (nWr != 4) begin
         failures++;
         $display("[TB] FAIL write_count got=%0d want=4", nWr);
      end
      checks++;
      if (nFirst != 4) begin
         failures++;
         $display("[TB] FAIL tap_first_count got=%0d want=4", nFirst);
      end
      checks++;
      if (doneAt != 44) begin
         failures++;
         $display("[TB] FAIL complete_time got=%0d want=44", doneAt);
      end
      prevSel[0] = 3'd7;
      prevAddrb[0] = 12'd10;
   endtask

   task automatic test_start_while_busy();
      int midAt, nWr;
      obs_t e;
      midAt = $urandom_range(1, frameCycles(0) - 2);
      captureFrame(0, midAt);
      nWr = 0;
      for (int k = 0; k < obsQ.size(); k++) begin
         if (obsQ[k].wea1 === 1'b1) nWr++;
         e = modelAt(0, k, prevSel[0], prevAddrb[0]);
         checks++;
         if (masked(obsQ[k]) !== e) begin
            failures++;
            $display("[TB] FAIL busy_start mid=%0d k=%0d got=%h want=%h", midAt, k, masked(obsQ[k]), e);
         end
      end
      checks++;
      if (nWr != 4) begin
         failures++;
         $display("[TB] FAIL busy_start_writes got=%0d want=4", nWr);
      end
      prevSel[0] = 3'd7;
      prevAddrb[0] = 12'd10;
   endtask

   task automatic test_done_restart();
      checks++;
      if (obs[0].complete !== 1'b1) begin
         failures++;
         $display("[TB] FAIL done_level got=%b want=1", obs[0].complete);
      end
      captureFrame(0, -1);
      checks++;
      if (obsQ[0].complete !== 1'b0 || obsQ[0].ena !== 1'b1 || obsQ[0].addra !== 12'd0) begin
         failures++;
         $display("[TB] FAIL done_restart got complete=%b ena=%b addra=%0d want 0/1/0",
                  obsQ[0].complete, obsQ[0].ena, obsQ[0].addra);
      end
      prevSel[0] = 3'd7;
      prevAddrb[0] = 12'd10;
   endtask

   task automatic test_reset_mid_frame();
      obs_t e;
      @(negedge clk);
      startv[0] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         startv[0] = 1'b0;
      end
      checks++;
      if (obs[0].busy !== 1'b1 || obs[0].ena !== 1'b0 || obs[0].wea1 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL drain_state got busy=%b ena=%b wea1=%b want 1/0/0", obs[0].busy, obs[0].ena, obs[0].wea1);
      end
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i] !== '0) begin
            failures++;
            $display("[TB] FAIL abort_reset inst%0d got=%h want=0", i, obs[i]);
         end
         prevSel[i]   = '0;
         prevAddrb[i] = '0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (obs[0] !== '0) begin
            failures++;
            $display("[TB] FAIL abort_quiet cyc=%0d got=%h want=0", c, obs[0]);
         end
      end
      captureFrame(0, -1);
      for (int k = 0; k < obsQ.size(); k++) begin
         e = modelAt(0, k, prevSel[0], prevAddrb[0]);
         checks++;
         if (masked(obsQ[k]) !== e) begin
            failures++;
            $display("[TB] FAIL rerun k=%0d got=%h want=%h", k, masked(obsQ[k]), e);
         end
      end
      checks++;
      if (obsQ[10].wea1 !== 1'b1 || obsQ[10].addrb !== 12'd5) begin
         failures++;
         $display("[TB] FAIL rerun_first_write got wea1=%b addrb=%0d want 1/5", obsQ[10].wea1, obsQ[10].addrb);
      end
      prevSel[0] = 3'd7;
      prevAddrb[0] = 12'd10;
   endtask

   task automatic test_rdlat1();
      obs_t e;
      int doneAt;
      for (int rep = 0; rep < 2; rep++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         captureFrame(1, -1);
         doneAt = -1;
         for (int k = 0; k < obsQ.size(); k++) begin
            if (doneAt < 0 && obsQ[k].complete === 1'b1) doneAt = k;
            e = modelAt(1, k, prevSel[1], prevAddrb[1]);
            checks++;
            if (masked(obsQ[k]) !== e) begin
               failures++;
               $display("[TB] FAIL rdlat1 rep=%0d k=%0d got=%h want=%h", rep, k, masked(obsQ[k]), e);
            end
         end
         checks++;
         if (doneAt != 40) begin
            failures++;
            $display("[TB] FAIL rdlat1_time rep=%0d got=%0d want=40", rep, doneAt);
         end
         prevSel[1] = 3'd7;
         prevAddrb[1] = 12'd10;
      end
   endtask

   task automatic test_random_config();
      obs_t e;
      for (int rep = 0; rep < 2; rep++) begin
         repeat ($urandom_range(0, 6)) @(negedge clk);
         captureFrame(2, (rep == 1) ? int'($urandom_range(1, frameCycles(2) - 2)) : -1);
         for (int k = 0; k < obsQ.size(); k++) begin
            e = modelAt(2, k, prevSel[2], prevAddrb[2]);
            checks++;
            if (masked(obsQ[k]) !== e) begin
               failures++;
               $display("[TB] FAIL cfg6x5 rep=%0d k=%0d got=%h want=%h", rep, k, masked(obsQ[k]), e);
            end
         end
         prevSel[2] = 3'd7;
         prevAddrb[2] = 12'd22;
      end
   endtask

   task automatic test_back_to_back();
      int per;
      obs_t e;
      per = frameCycles(0);
      obsQ.delete();
      @(negedge clk);
      startv[0] = 1'b1;
      for (int k = 0; k < 2 * per + 2; k++) begin
         @(negedge clk);
         obsQ.push_back(obs[0]);
         if (k == per + 1) startv[0] = 1'b0;
      end
      startv[0] = 1'b0;
      for (int k = 0; k < obsQ.size(); k++) begin
         if (k <= per) e = modelAt(0, k, prevSel[0], prevAddrb[0]);
         else          e = modelAt(0, k - per - 1, 3'd7, 12'd10);
         checks++;
         if (masked(obsQ[k]) !== e) begin
            failures++;
            $display("[TB] FAIL back_to_back k=%0d got=%h want=%h", k, masked(obsQ[k]), e);
         end
      end
      prevSel[0] = 3'd7;
      prevAddrb[0] = 12'd10;
   endtask

   // Scenario sequence; ends with the summary line.
   initial begin
      checks   = 0;
      failures = 0;
      startv   = '0;
      rst_n    = 1'b1;
      test_reset();
      test_frame_4x4();
      test_start_while_busy();
      test_done_restart();
      test_reset_mid_frame();
      test_rdlat1();
      test_random_config();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
